// File: rtl/banner_scroller_if.sv
`default_nettype none
// ============================================================================
//  Module   : banner_scroller_if
//  Purpose  : Bundles the strobe, control, message-write and display signals
//             of banner_scroller into one interface.
//             master : the side that drives ticks/control/writes and watches
//                      the display pins (tick generator, CPU, testbench).
//             slave  : the banner_scroller itself.
//  Signals  : tick_display, tick_banner  1-cycle strobes
//             enable                     1 = run/display, 0 = freeze + blank
//             wr_en, wr_addr, wr_data    message buffer write port
//             msg_len                    active message length (AW+1 bits)
//             anode                      active-low digit enables (one-cold)
//             seg                        active-low segments {g,f,e,d,c,b,a}
//  Revision : 1.0  initial release
// ============================================================================
interface banner_scroller_if #(
    parameter int NUM_DIGITS = 4,
    parameter int AW         = 4
);
    logic                  tick_display;
    logic                  tick_banner;
    logic                  enable;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [4:0]            wr_data;
    logic [AW:0]           msg_len;
    logic [NUM_DIGITS-1:0] anode;
    logic [6:0]            seg;

    modport master (
        output tick_display,
        output tick_banner,
        output enable,
        output wr_en,
        output wr_addr,
        output wr_data,
        output msg_len,
        input  anode,
        input  seg
    );

    modport slave (
        input  tick_display,
        input  tick_banner,
        input  enable,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  msg_len,
        output anode,
        output seg
    );
endinterface : banner_scroller_if
`default_nettype wire

// File: rtl/banner_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : banner_scroller
//  Purpose  : Drives a multiplexed common-anode 7-segment display with a
//             scrolling message held in a small writable buffer. The digit
//             scan advances on tick_display, the scroll position on
//             tick_banner. anode/seg are registered (1-cycle latency from any
//             internal state change).
//  Ports    : clk   in  system clock
//             rst   in  synchronous reset, active-low
//             bus   slave modport of banner_scroller_if (ticks, enable,
//                   buffer write port, msg_len, anode/seg outputs)
//  Revision : 1.0  initial release
// ============================================================================
module banner_scroller #(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int AW         = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    banner_scroller_if.slave   bus
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int DSW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough for scroll_ptr + NUM_DIGITS-1 without overflow.
    localparam int SW  = AW + DSW + 1;

    localparam logic [6:0]    c_seg_blank  = 7'h7F;
    localparam logic [4:0]    c_chr_blank  = 5'h1F;
    localparam logic [DSW-1:0] c_last_digit = DSW'(NUM_DIGITS - 1);
    localparam logic [AW:0]   c_max_len    = (AW+1)'(MSG_DEPTH);

    // ------------------------------------------------------------------
    // Character code -> active-low segment pattern {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_glyph(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'h00:   g = 7'b1000000; // 0
            5'h01:   g = 7'b1111001; // 1
            5'h02:   g = 7'b0100100; // 2
            5'h03:   g = 7'b0110000; // 3
            5'h04:   g = 7'b0011001; // 4
            5'h05:   g = 7'b0010010; // 5
            5'h06:   g = 7'b0000010; // 6
            5'h07:   g = 7'b1111000; // 7
            5'h08:   g = 7'b0000000; // 8
            5'h09:   g = 7'b0010000; // 9
            5'h0A:   g = 7'b0001000; // A
            5'h0B:   g = 7'b0000011; // b
            5'h0C:   g = 7'b1000110; // C
            5'h0D:   g = 7'b0100001; // d
            5'h0E:   g = 7'b0000110; // E
            5'h0F:   g = 7'b0001110; // F
            5'h10:   g = 7'b0111111; // '-' : segment g only
            default: g = c_seg_blank;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]            r_buf [MSG_DEPTH];
    logic [DSW-1:0]        r_digit_sel;
    logic [AW-1:0]         r_scroll_ptr;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [6:0]            r_seg;

    // ------------------------------------------------------------------
    // Effective message length: 0 is treated as 1, and anything beyond
    // the buffer depth saturates, so the modulo below never divides by 0
    // and never indexes past the buffer.
    // ------------------------------------------------------------------
    logic [AW:0] w_eff_len;

    always_comb begin
        w_eff_len = bus.msg_len;
        if (bus.msg_len == '0) begin
            w_eff_len = (AW+1)'(1);
        end else if (bus.msg_len > c_max_len) begin
            w_eff_len = c_max_len;
        end
    end

    // ------------------------------------------------------------------
    // Scroll pointer next-state helpers
    // ------------------------------------------------------------------
    logic [AW:0] w_ptr_ext;
    logic [AW:0] w_ptr_inc;
    logic        w_ptr_out_of_range;

    always_comb begin
        w_ptr_ext          = {1'b0, r_scroll_ptr};
        w_ptr_inc          = w_ptr_ext + (AW+1)'(1);
        w_ptr_out_of_range = (w_ptr_ext >= w_eff_len);
    end

    // ------------------------------------------------------------------
    // Character index for the digit currently scanned.
    // Digit k shows buf[(scroll_ptr + NUM_DIGITS-1-k) mod L]; a true modulo
    // keeps the mapping right even when L < NUM_DIGITS (several wraps) and
    // during the single cycle where scroll_ptr may still be >= L.
    // ------------------------------------------------------------------
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_mod;
    logic [AW-1:0] w_idx;

    always_comb begin
        w_sum = SW'(r_scroll_ptr) + SW'(NUM_DIGITS - 1) - SW'(r_digit_sel);
        w_mod = w_sum % SW'(w_eff_len);
        w_idx = AW'(w_mod);
    end

    // ------------------------------------------------------------------
    // One-cold anode decode of the current digit
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] w_anode;

    always_comb begin
        w_anode = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_digit_sel == DSW'(k)) begin
                w_anode[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Message buffer: resets to blank; writes are accepted regardless of
    // enable. Out-of-range addresses are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                r_buf[i] <= c_chr_blank;
            end
        end else if (bus.wr_en && (int'(bus.wr_addr) < MSG_DEPTH)) begin
            r_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Digit scan counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_digit_sel <= '0;
        end else if (bus.enable && bus.tick_display) begin
            if (r_digit_sel == c_last_digit) begin
                r_digit_sel <= '0;
            end else begin
                r_digit_sel <= r_digit_sel + DSW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scroll pointer. A pointer left stranded by a shrinking msg_len is
    // pulled back to 0 first; that takes priority over a banner tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scroll_ptr <= '0;
        end else if (w_ptr_out_of_range) begin
            r_scroll_ptr <= '0;
        end else if (bus.enable && bus.tick_banner) begin
            if (w_ptr_inc >= w_eff_len) begin
                r_scroll_ptr <= '0;
            end else begin
                r_scroll_ptr <= AW'(w_ptr_inc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered display outputs, recomputed every cycle from current state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_anode <= '1;
            r_seg   <= c_seg_blank;
        end else if (!bus.enable) begin
            r_anode <= '1;
            r_seg   <= c_seg_blank;
        end else begin
            r_anode <= w_anode;
            r_seg   <= f_glyph(r_buf[w_idx]);
        end
    end

    assign bus.anode = r_anode;
    assign bus.seg   = r_seg;

endmodule : banner_scroller
`default_nettype wire

// File: tb/tb_banner_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_banner_scroller
//  Purpose  : Self-checking bench for banner_scroller. A table of single-tick
//             vectors walks the scan/scroll state, then hand-written sequences
//             cover reset, freeze, short messages, length shrink and reset
//             mid-operation. Expected values are hand-computed constants.
//  Revision : 1.0  initial release
// ============================================================================
module tb_banner_scroller;

    localparam int NUM_DIGITS = 4;
    localparam int MSG_DEPTH  = 16;
    localparam int AW         = 4;

    // Active-low glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] GD = 7'b0111111; // '-'
    localparam logic [6:0] GB = 7'h7F;      // blank

    logic clk;
    logic rst;

    banner_scroller_if #(.NUM_DIGITS(NUM_DIGITS), .AW(AW)) bus ();

    banner_scroller #(
        .NUM_DIGITS(NUM_DIGITS),
        .MSG_DEPTH (MSG_DEPTH),
        .AW        (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       td;
        logic       tb;
        logic       en;
        logic [3:0] exp_anode;
        logic [6:0] exp_seg;
    } vec_t;

    vec_t vecs [15];

    // Advance n clock edges, then sit 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es);
        n_tests++;
        if (bus.anode !== ea || bus.seg !== es) begin
            n_fail++;
            $display("FAIL %s: anode=%b seg=%b, expected anode=%b seg=%b",
                     name, bus.anode, bus.seg, ea, es);
        end
    endtask

    task automatic write(input logic [3:0] a, input logic [4:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step(1);
        bus.wr_en   = 1'b0;
    endtask

    // One strobe cycle followed by one idle cycle, so the outputs reflect
    // the updated state when this returns.
    task automatic pulse(input logic td, input logic tb);
        bus.tick_display = td;
        bus.tick_banner  = tb;
        step(1);
        bus.tick_display = 1'b0;
        bus.tick_banner  = 1'b0;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vectors start from: msg_len=4, buf=0,1,2,3, digit0, scroll0
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'b1101, G2}; // d1 s0
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'b1011, G1}; // d2
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'b0111, G0}; // d3
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'b1110, G3}; // d0 (wrap)
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'b1110, G0}; // s1
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'b1101, G3}; // d1
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'b1011, G2}; // d2
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'b0111, G1}; // d3
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'b0111, G2}; // s2
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'b0111, G3}; // s3
        vecs[10] = '{1'b0, 1'b1, 1'b1, 4'b0111, G0}; // s0 (wrap)
        vecs[11] = '{1'b1, 1'b1, 1'b1, 4'b1110, G0}; // d0 s1 same edge
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'b1111, GB}; // frozen, blank
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'b1111, GB}; // frozen, blank
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'b1110, G0}; // resume d0 s1

        rst              = 1'b0;
        bus.enable       = 1'b1;
        bus.tick_display = 1'b1; // must be ignored during reset
        bus.tick_banner  = 1'b1;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.msg_len      = 5'd4;

        // ---- reset ----
        step(3);
        check("reset_hold", 4'b1111, GB);
        bus.tick_display = 1'b0;
        bus.tick_banner  = 1'b0;
        rst = 1'b1;
        step(1);
        check("reset_release", 4'b1110, GB);

        // ---- load message 0,1,2,3 ----
        for (int i = 0; i < 4; i++) write(4'(i), 5'(i));
        step(1);
        check("after_write", 4'b1110, G3);

        // ---- single-tick table ----
        for (int i = 0; i < 15; i++) begin
            bus.enable       = vecs[i].en;
            bus.tick_display = vecs[i].td;
            bus.tick_banner  = vecs[i].tb;
            step(1);
            bus.tick_display = 1'b0;
            bus.tick_banner  = 1'b0;
            step(1);
            check($sformatf("vec%0d", i), vecs[i].exp_anode, vecs[i].exp_seg);
        end

        // ---- freeze with 10 ticks, write while frozen ----
        bus.enable       = 1'b0;
        bus.tick_display = 1'b1;
        bus.tick_banner  = 1'b1;
        step(10);
        bus.tick_display = 1'b0;
        bus.tick_banner  = 1'b0;
        write(4'd0, 5'h10);
        step(1);
        check("frozen_blank", 4'b1111, GB);
        bus.enable = 1'b1;
        step(1);
        check("resume_dash", 4'b1110, GD); // d0 s1 -> buf[0]

        // ---- msg_len=2, buf=0,1 ----
        write(4'd0, 5'h00);
        bus.msg_len = 5'd2;
        step(1);
        pulse(1'b0, 1'b1); // scroll 1 -> 0
        check("len2_s0_d0", 4'b1110, G1);
        pulse(1'b1, 1'b0);
        check("len2_s0_d1", 4'b1101, G0);
        pulse(1'b1, 1'b0);
        check("len2_s0_d2", 4'b1011, G1);
        pulse(1'b1, 1'b0);
        check("len2_s0_d3", 4'b0111, G0);
        pulse(1'b0, 1'b1);
        check("len2_s1_d3", 4'b0111, G1);
        pulse(1'b1, 1'b0);
        check("len2_s1_d0", 4'b1110, G0);
        pulse(1'b1, 1'b0);
        check("len2_s1_d1", 4'b1101, G1);
        pulse(1'b1, 1'b0);
        check("len2_s1_d2", 4'b1011, G0);

        // ---- shrink msg_len with stranded scroll_ptr (digit 2) ----
        bus.msg_len = 5'd8;
        for (int i = 4; i < 8; i++) write(4'(i), 5'(i));
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1); // scroll 1 -> 5
        check("len8_s5", 4'b1011, G6);
        bus.msg_len = 5'd3;
        step(2);
        check("shrink_clamp", 4'b1011, G1);
        bus.msg_len = 5'd8;
        step(1);
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1); // scroll 0 -> 5
        check("len8_s5_again", 4'b1011, G6);
        bus.msg_len     = 5'd3;
        bus.tick_banner = 1'b1;
        step(1);
        bus.tick_banner = 1'b0;
        step(1);
        check("shrink_clamp_tick", 4'b1011, G1);

        // ---- length edge cases (digit 2, scroll 0) ----
        bus.msg_len = 5'd0;
        step(2);
        check("len0_as_1", 4'b1011, G0);
        bus.msg_len = 5'd31;
        step(2);
        check("len31_sat", 4'b1011, G1);
        for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1); // scroll 0 -> 7
        check("len16_s7_blank", 4'b1011, GB);
        bus.msg_len = 5'd3;
        step(2);                                        // scroll clamps to 0
        check("len3_d2", 4'b1011, G1);
        pulse(1'b1, 1'b0);
        check("len3_d3", 4'b0111, G0);
        pulse(1'b1, 1'b0);
        check("len3_d0_wrap", 4'b1110, G0);
        pulse(1'b1, 1'b0);
        check("len3_d1", 4'b1101, G2);

        // ---- reset mid-operation clears buffer and counters ----
        rst = 1'b0;
        step(1);
        check("midreset_hold", 4'b1111, GB);
        rst = 1'b1;
        step(1);
        check("midreset_release", 4'b1110, GB);
        pulse(1'b1, 1'b0);
        check("midreset_buf_blank", 4'b1101, GB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_banner_scroller
`default_nettype wire
